port_rx_buffer: RTL and testbench

- Receive-side stage directly downstream of one switch_port output: it consumes the port's data_op/valid_op stream and throttles the switch through suspend_op.
- Buffers each 16-bit packet word {data[7:0], source[3:0], target[3:0]} in a first-word-fall-through FIFO and classifies it by target field.
- Presents packets to a sink over a valid/ready handshake and keeps saturating per-class statistics for the port.

---
 rtl/port_rx_buffer.sv | 102 ++++++++++
 tb/tb_port_rx_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/port_rx_buffer.sv
// Receive buffer behind one switch output: FWFT FIFO with target-field classification,
// registered back-pressure and saturating per-class packet statistics.
module port_rx_buffer #(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2,
    parameter int PORT_ID      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_op,
    input  logic        valid_op,
    output logic        suspend_op,
    output logic [15:0] out_data,
    output logic [1:0]  out_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] pkt_count,
    output logic [7:0]  single_count,
    output logic [7:0]  mcast_count,
    output logic [7:0]  bcast_count,
    output logic [7:0]  err_count,
    output logic [7:0]  drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL   = DEPTH[AW:0];
    localparam logic [AW:0] MARGIN = AFULL_MARGIN[AW:0];

    logic [DEPTH-1:0][15:0] mem_data;
    logic [DEPTH-1:0][1:0]  mem_type;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count, count_next;
    logic                   push, pop, drop, err;
    logic [1:0]             cls;

    always_comb begin
        cls = 2'd2;
        case (data_op[3:0])
            4'b1111:                         cls = 2'd3;
            4'b0000:                         cls = 2'd0;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: cls = 2'd1;
            default:                         cls = 2'd2;
        endcase
    end

    assign err  = (data_op[3:0] == 4'b0000) || !data_op[PORT_ID];
    assign pop  = out_valid && out_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign push = valid_op && ((count != FULL) || pop);
    assign drop = valid_op && !push;

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    // Head is gated so the outputs read zero whenever nothing is buffered.
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr] : 16'h0000;
    assign out_type  = out_valid ? mem_type[rd_ptr] : 2'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= data_op;
            mem_type[wr_ptr] <= cls;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            suspend_op <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            suspend_op <= (FULL - count_next) <= MARGIN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count    <= '0;
            single_count <= '0;
            mcast_count  <= '0;
            bcast_count  <= '0;
            err_count    <= '0;
            drop_count   <= '0;
        end else begin
            if (push) begin
                if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
                if (cls == 2'd1 && single_count != 8'hFF) single_count <= single_count + 8'd1;
                if (cls == 2'd2 && mcast_count != 8'hFF)  mcast_count  <= mcast_count + 8'd1;
                if (cls == 2'd3 && bcast_count != 8'hFF)  bcast_count  <= bcast_count + 8'd1;
                if (err && err_count != 8'hFF)            err_count    <= err_count + 8'd1;
            end
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_port_rx_buffer.sv
// Directed bench for port_rx_buffer (DEPTH=8, AFULL_MARGIN=2, PORT_ID=0).
module tb_port_rx_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_op = '0;
    logic        valid_op = 1'b0;
    logic        suspend_op;
    logic [15:0] out_data;
    logic [1:0]  out_type;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] pkt_count;
    logic [7:0]  single_count, mcast_count, bcast_count, err_count, drop_count;

    int vectors = 0;
    int errs = 0;
    logic [15:0] q[$];

    port_rx_buffer #(.DEPTH(8), .AFULL_MARGIN(2), .PORT_ID(0)) dut (
        .clk(clk), .reset(reset), .data_op(data_op), .valid_op(valid_op),
        .suspend_op(suspend_op), .out_data(out_data), .out_type(out_type),
        .out_valid(out_valid), .out_ready(out_ready), .pkt_count(pkt_count),
        .single_count(single_count), .mcast_count(mcast_count),
        .bcast_count(bcast_count), .err_count(err_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge; the queue tracks which words should be held, in order.
    task automatic step();
        bit p, u;
        p = (q.size() > 0) && out_ready;
        u = valid_op && ((q.size() < 8) || p);
        @(posedge clk);
        #1;
        if (p) void'(q.pop_front());
        if (u) q.push_back(data_op);
    endtask

    task automatic chk_head(input string tag);
        if (q.size() == 0) chk(tag, {31'b0, out_valid}, 32'd0);
        else begin
            chk(tag, {31'b0, out_valid}, 32'd1);
            chk(tag, {16'b0, out_data}, {16'b0, q[0]});
        end
    endtask

    initial begin
        #12;
        chk("rst_valid",   {31'b0, out_valid}, 0);
        chk("rst_suspend", {31'b0, suspend_op}, 0);
        chk("rst_data",    {16'b0, out_data}, 0);
        chk("rst_type",    {30'b0, out_type}, 0);
        chk("rst_pkt",     {16'b0, pkt_count}, 0);
        chk("rst_drop",    {24'b0, drop_count}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Broadcast word
        out_ready = 1'b1; valid_op = 1'b1; data_op = 16'hA50F;
        step();
        chk("bc_valid", {31'b0, out_valid}, 1);
        chk("bc_data",  {16'b0, out_data}, 32'hA50F);
        chk("bc_type",  {30'b0, out_type}, 3);
        chk("bc_pkt",   {16'b0, pkt_count}, 1);
        chk("bc_bcast", {24'b0, bcast_count}, 1);
        chk("bc_err",   {24'b0, err_count}, 0);
        valid_op = 1'b0;
        step();
        chk("bc_drain", {31'b0, out_valid}, 0);

        // Single-bit target 2 (misrouted for port 0), then multicast target 6
        valid_op = 1'b1; data_op = 16'h3312;
        step();
        chk("sg_type",   {30'b0, out_type}, 1);
        chk("sg_data",   {16'b0, out_data}, 32'h3312);
        chk("sg_single", {24'b0, single_count}, 1);
        chk("sg_err",    {24'b0, err_count}, 1);
        data_op = 16'h3316;
        step();
        chk("mc_data",  {16'b0, out_data}, 32'h3316);
        chk("mc_type",  {30'b0, out_type}, 2);
        chk("mc_mcast", {24'b0, mcast_count}, 1);
        chk("mc_err",   {24'b0, err_count}, 2);
        chk("mc_pkt",   {16'b0, pkt_count}, 3);
        valid_op = 1'b0;
        step();
        chk("mc_drain", {31'b0, out_valid}, 0);

        // Burst of 10 with sink stalled: suspend at 6th store, 2 drops
        out_ready = 1'b0; valid_op = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_op = {8'h40 + 8'(i), 4'h5, 4'h1};
            step();
            if (i == 4) chk("burst_nosusp5", {31'b0, suspend_op}, 0);
            if (i == 5) chk("burst_susp6",   {31'b0, suspend_op}, 1);
        end
        chk("burst_drop",   {24'b0, drop_count}, 2);
        chk("burst_pkt",    {16'b0, pkt_count}, 11);
        chk("burst_single", {24'b0, single_count}, 9);
        chk("burst_head",   {16'b0, out_data}, 32'h4051);
        chk("burst_qsize",  q.size(), 8);

        // Full FIFO, push and pop together for 4 edges
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_op = {8'hC0 + 8'(i), 4'h6, 4'h1};
            step();
            chk_head("full_pp");
            chk("full_pp_susp", {31'b0, suspend_op}, 1);
        end
        chk("full_pp_drop", {24'b0, drop_count}, 2);
        chk("full_pp_pkt",  {16'b0, pkt_count}, 15);
        chk("full_pp_head", {16'b0, out_data}, 32'h4451);
        valid_op = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_head("drain");
        end
        chk("drain_susp", {31'b0, suspend_op}, 0);

        // Target 0: unknown class, error, delivered as-is
        valid_op = 1'b1; data_op = 16'h7700;
        step();
        chk("unk_type", {30'b0, out_type}, 0);
        chk("unk_data", {16'b0, out_data}, 32'h7700);
        chk("unk_err",  {24'b0, err_count}, 3);
        chk("unk_pkt",  {16'b0, pkt_count}, 16);
        valid_op = 1'b0;
        step();

        // Six buffered, suspend high, then async reset
        out_ready = 1'b0; valid_op = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_op = {8'h90 + 8'(i), 4'h2, 4'hF};
            step();
        end
        chk("pre_rst_susp", {31'b0, suspend_op}, 1);
        valid_op = 1'b0;
        #2 reset = 1'b1;
        #1;
        q.delete();
        chk("arst_valid", {31'b0, out_valid}, 0);
        chk("arst_susp",  {31'b0, suspend_op}, 0);
        chk("arst_pkt",   {16'b0, pkt_count}, 0);
        chk("arst_bcast", {24'b0, bcast_count}, 0);
        chk("arst_err",   {24'b0, err_count}, 0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_idle", {31'b0, out_valid}, 0);
        valid_op = 1'b1; data_op = 16'hBEEF;
        step();
        chk("post_rst_head", {16'b0, out_data}, 32'hBEEF);
        chk("post_rst_pkt",  {16'b0, pkt_count}, 1);

        // Drop counter saturation
        data_op = 16'h1111;
        for (int i = 0; i < 265; i++) step();
        chk("sat_drop",  {24'b0, drop_count}, 32'hFF);
        chk("sat_pkt",   {16'b0, pkt_count}, 8);
        chk("sat_head",  {16'b0, out_data}, 32'hBEEF);
        valid_op = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
